// File: rtl/spike_fifo_arbiter.sv
// rtl/spike_fifo_arbiter.sv - round-robin burst reader draining spike FIFOs into one tagged stream
module spike_fifo_arbiter #(
   parameter int  NUM_SRC    = 4,
   parameter int  DATA_WIDTH = 16,
   parameter int  MAX_BURST  = 4,
   localparam int ID_WIDTH   = $clog2(NUM_SRC)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [NUM_SRC-1:0]            src_mask,
   input  logic [NUM_SRC-1:0]            src_empty,
   output logic [NUM_SRC-1:0]            src_rd_en,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_rd_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA_WIDTH-1:0]         m_data,
   output logic [ID_WIDTH-1:0]           m_src_id,
   output logic                          busy,
   input  logic                          cnt_clr,
   output logic [31:0]                   event_count
);

   localparam int                  BURST_W     = $clog2(MAX_BURST + 1);
   localparam logic [BURST_W-1:0]  BURST_LIMIT = BURST_W'(MAX_BURST);
   localparam logic [ID_WIDTH-1:0] LAST_ID     = ID_WIDTH'(NUM_SRC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   state_t                  state;
   logic [ID_WIDTH-1:0]     grant;
   logic [ID_WIDTH-1:0]     last_grant;
   logic [ID_WIDTH-1:0]     arb_idx;
   logic [ID_WIDTH-1:0]     cand;
   logic                    arb_found;
   logic [BURST_W-1:0]      burst_cnt;
   logic [BURST_W-1:0]      burst_nxt;
   logic [NUM_SRC-1:0]      req;
   logic [DATA_WIDTH-1:0]   rd_word [NUM_SRC];
   logic                    handshake;
   logic                    burst_more;

   // one-hot read strobe for a source index
   function automatic logic [NUM_SRC-1:0] onehot(input logic [ID_WIDTH-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   assign req        = ~src_empty & src_mask;
   assign burst_nxt  = burst_cnt + 1'b1;
   assign handshake  = (state == ST_OUT) && m_valid && m_ready;
   assign burst_more = (burst_nxt < BURST_LIMIT) && req[grant] && enable;

   // unpack the flat read-data bus so the granted word is a plain array lookup
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
         assign rd_word[gi] = src_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // circular search for the first requester after the previous grant
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = last_grant;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
         if (!arb_found && req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   // scheduler FSM: IDLE -> READ -> WAIT -> OUT, looping back to READ while the burst continues
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last_grant <= LAST_ID;
         burst_cnt  <= '0;
         src_rd_en  <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_src_id   <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable && arb_found) begin
                  grant     <= arb_idx;
                  burst_cnt <= '0;
                  src_rd_en <= onehot(arb_idx);
                  busy      <= 1'b1;
                  state     <= ST_READ;
               end
            end
            ST_READ: begin
               src_rd_en <= '0;
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               m_data   <= rd_word[grant];
               m_src_id <= grant;
               m_valid  <= 1'b1;
               state    <= ST_OUT;
            end
            ST_OUT: begin
               if (m_ready) begin
                  m_valid   <= 1'b0;
                  burst_cnt <= burst_nxt;
                  if (burst_more) begin
                     src_rd_en <= onehot(grant);
                     state     <= ST_READ;
                  end else begin
                     last_grant <= grant;
                     busy       <= 1'b0;
                     state      <= ST_IDLE;
                  end
               end
            end
            default: begin
               src_rd_en <= '0;
               m_valid   <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   // completed-handshake counter; clear wins over a coincident increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_count <= '0;
      end else if (cnt_clr) begin
         event_count <= '0;
      end else if (handshake) begin
         event_count <= event_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_spike_fifo_arbiter.sv
// tb/tb_spike_fifo_arbiter.sv - randomized self-checking bench with a transaction-level arbiter model
module tb_spike_fifo_arbiter;
   localparam int NUM_SRC = 4;
   localparam int DW      = 16;
   localparam int MB      = 4;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic                  enable = 1'b0;
   logic [NUM_SRC-1:0]    src_mask = '1;
   logic [NUM_SRC-1:0]    src_empty;
   logic [NUM_SRC-1:0]    src_rd_en;
   logic [NUM_SRC*DW-1:0] src_rd_data;
   logic                  m_valid;
   logic                  m_ready = 1'b0;
   logic [DW-1:0]         m_data;
   logic [1:0]            m_src_id;
   logic                  busy;
   logic                  cnt_clr = 1'b0;
   logic [31:0]           event_count;

   spike_fifo_arbiter #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .src_mask(src_mask),
      .src_empty(src_empty), .src_rd_en(src_rd_en), .src_rd_data(src_rd_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_src_id(m_src_id),
      .busy(busy), .cnt_clr(cnt_clr), .event_count(event_count)
   );

   always #10 clk = ~clk;

   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   bit            chk_en = 1'b0;
   logic [DW-1:0] fq [NUM_SRC][$];
   logic [DW-1:0] mq [NUM_SRC][$];
   logic [DW-1:0] rd_word [NUM_SRC];
   int            rd_pulses [NUM_SRC];
   int            hs_id [$];
   int            hs_cyc [$];
   logic [DW-1:0] hs_d [$];
   int            m_last = NUM_SRC - 1;
   int            m_grant = 0;
   int            m_burst = 0;
   bit            m_cont = 1'b0;
   longint        m_cnt = 0;
   bit            prev_v = 1'b0;
   bit            prev_r = 1'b0;
   logic [DW-1:0] prev_d;
   logic [1:0]    prev_id;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int s, input logic [DW-1:0] d);
      fq[s].push_back(d);
      mq[s].push_back(d);
   endtask

   // source FIFO models: registered read data, empty flag follows the queue
   initial forever begin
      @(negedge clk); #1;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (chk_en && src_rd_en[i] === 1'b1) begin
            rd_pulses[i]++;
            chk($sformatf("rd_nonempty[%0d]", i), fq[i].size() > 0, 1);
            if (fq[i].size() > 0) rd_word[i] = fq[i].pop_front();
         end
         src_empty[i] = (fq[i].size() == 0);
         src_rd_data[i*DW +: DW] = rd_word[i];
      end
   end

   // model: predict each accepted word from round-robin + burst rules
   task automatic model_handshake();
      int id = -1;
      logic [DW-1:0] exp_d;
      if (m_cont) id = m_grant;
      else begin
         for (int k = 1; k <= NUM_SRC; k++) begin
            int j = (m_last + k) % NUM_SRC;
            if (id < 0 && src_mask[j] && mq[j].size() > 0) id = j;
         end
      end
      chk("grant_id", m_src_id, id);
      hs_id.push_back(int'(m_src_id));
      hs_cyc.push_back(cyc);
      hs_d.push_back(m_data);
      if (id >= 0 && mq[id].size() > 0) begin
         exp_d = mq[id].pop_front();
         chk("data", m_data, exp_d);
         if (!m_cont) begin
            m_grant = id;
            m_burst = 0;
         end
         m_burst++;
         m_cont = (m_burst < MB) && (mq[id].size() > 0) && src_mask[id] && enable;
         if (!m_cont) m_last = id;
      end
   endtask

   // per-cycle compare against the model and stream invariants
   initial forever begin
      @(negedge clk); #2;
      cyc++;
      if (!chk_en) begin
         prev_v = 1'b0;
      end else begin
         chk("event_count", event_count, m_cnt & 64'hFFFF_FFFF);
         chk("rd_en_onehot_in_busy", (src_rd_en == '0) || ($onehot(src_rd_en) && busy), 1);
         chk("busy_with_valid", !m_valid || busy, 1);
         if (prev_v && !prev_r) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_d);
            chk("hold_id", m_src_id, prev_id);
         end
         if (m_valid && m_ready) model_handshake();
         m_cnt = cnt_clr ? 0 : m_cnt + ((m_valid && m_ready) ? 1 : 0);
         prev_v  = m_valid;
         prev_r  = m_ready;
         prev_d  = m_data;
         prev_id = m_src_id;
      end
   end

   function automatic bit drained();
      for (int i = 0; i < NUM_SRC; i++)
         if (src_mask[i] && fq[i].size() > 0) return 1'b0;
      return !busy && !m_valid;
   endfunction

   task automatic wait_drain(input int budget, input bit rnd);
      int n = 0;
      while (!drained() && n < budget) begin
         @(negedge clk);
         if (rnd) begin
            m_ready = ($urandom_range(3) != 0);
            enable  = ($urandom_range(7) != 0);
         end
         #3;
         n++;
      end
      chk("drain_in_budget", drained(), 1);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!m_valid && n < budget) begin
         @(negedge clk); #3;
         n++;
      end
      chk("valid_in_budget", m_valid, 1);
   endtask

   task automatic do_reset();
      @(negedge clk); #4;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", src_rd_en, 0);
      chk("rst_count", event_count, 0);
      chk("rst_data", m_data, 0);
      chk("rst_id", m_src_id, 0);
      for (int i = 0; i < NUM_SRC; i++) begin
         fq[i].delete();
         mq[i].delete();
      end
      m_last = NUM_SRC - 1; m_cont = 1'b0; m_burst = 0; m_grant = 0; m_cnt = 0;
      @(negedge clk); #4;
      rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int base;
      int p0;
      int n;
      int ec;
      int exp_ids [$];
      logic [DW-1:0] t2 [3];
      int t5 [12];
      t2 = '{16'h00A1, 16'h00B2, 16'h00C3};
      t5 = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1, 3, 3};
      for (int i = 0; i < NUM_SRC; i++) begin
         rd_word[i] = '0;
         rd_pulses[i] = 0;
      end

      // 1: reset and idle with nothing to read
      do_reset();
      enable = 1'b1; m_ready = 1'b1; src_mask = '1;
      p0 = rd_pulses[0] + rd_pulses[1] + rd_pulses[2] + rd_pulses[3];
      repeat (20) begin
         @(negedge clk); #3;
         chk("idle_quiet", {busy, m_valid, src_rd_en}, 0);
      end
      chk("idle_no_reads", rd_pulses[0] + rd_pulses[1] + rd_pulses[2] + rd_pulses[3] - p0, 0);

      // 2: single source, latency and ordering
      @(negedge clk);
      base = hs_id.size();
      p0 = rd_pulses[2];
      for (int k = 0; k < 3; k++) push(2, t2[k]);
      n = 0;
      while (!m_valid && n < 10) begin
         @(negedge clk); #3;
         n++;
      end
      chk("first_valid_latency", n, 3);
      wait_drain(200, 1'b0);
      chk("src2_read_pulses", rd_pulses[2] - p0, 3);
      chk("t2_count", event_count, 3);
      chk("t2_words", hs_id.size() - base, 3);
      for (int k = 0; k < 3 && base + k < hs_id.size(); k++) begin
         chk($sformatf("t2_id[%0d]", k), hs_id[base+k], 2);
         chk($sformatf("t2_data[%0d]", k), hs_d[base+k], t2[k]);
      end

      // 3: all four sources loaded, bounded bursts and throughput
      do_reset();
      enable = 1'b1; m_ready = 1'b1; src_mask = '1;
      @(negedge clk);
      base = hs_id.size();
      for (int s = 0; s < NUM_SRC; s++)
         for (int k = 0; k < 6; k++) push(s, DW'($urandom));
      wait_drain(1000, 1'b0);
      exp_ids.delete();
      for (int s = 0; s < NUM_SRC; s++) repeat (4) exp_ids.push_back(s);
      for (int s = 0; s < NUM_SRC; s++) repeat (2) exp_ids.push_back(s);
      chk("t3_words", hs_id.size() - base, 24);
      for (int k = 0; k < 24 && base + k < hs_id.size(); k++) begin
         chk($sformatf("t3_id[%0d]", k), hs_id[base+k], exp_ids[k]);
         if (k > 0)
            chk($sformatf("t3_gap[%0d]", k), hs_cyc[base+k] - hs_cyc[base+k-1],
                (exp_ids[k] == exp_ids[k-1]) ? 3 : 4);
      end
      chk("t3_count", event_count, 24);

      // 5: masking; only odd sources, then drop source 1 mid-burst
      do_reset();
      enable = 1'b1; m_ready = 1'b1; src_mask = 4'b1010;
      @(negedge clk);
      base = hs_id.size();
      for (int s = 0; s < NUM_SRC; s++)
         for (int k = 0; k < 6; k++) push(s, DW'($urandom));
      wait_drain(1000, 1'b0);
      chk("t5_words", hs_id.size() - base, 12);
      for (int k = 0; k < 12 && base + k < hs_id.size(); k++)
         chk($sformatf("t5_id[%0d]", k), hs_id[base+k], t5[k]);
      @(negedge clk);
      base = hs_id.size();
      for (int k = 0; k < 6; k++) begin
         push(1, DW'($urandom));
         push(3, DW'($urandom));
      end
      n = 0;
      while (hs_id.size() < base + 2 && n < 100) begin
         @(negedge clk); #3;
         n++;
      end
      chk("t5_two_words", hs_id.size() >= base + 2, 1);
      @(negedge clk);
      src_mask = 4'b1000;
      wait_drain(1000, 1'b0);
      chk("t5b_words", hs_id.size() - base, 9);
      for (int k = 0; k < 9 && base + k < hs_id.size(); k++)
         chk($sformatf("t5b_id[%0d]", k), hs_id[base+k], (k < 3) ? 1 : 3);
      @(negedge clk);
      src_mask = '1;
      wait_drain(1000, 1'b0);

      // 4: backpressure holds the word and stalls reads
      @(negedge clk);
      m_ready = 1'b0;
      for (int k = 0; k < 3; k++) push(0, DW'($urandom));
      wait_valid(50);
      ec = event_count;
      repeat (10) begin
         @(negedge clk); #3;
         chk("bp_no_read", src_rd_en, 0);
         chk("bp_count", event_count, ec);
         chk("bp_valid", m_valid, 1);
      end
      @(negedge clk); m_ready = 1'b1;
      @(negedge clk); m_ready = 1'b0;
      #3;
      chk("bp_one_handshake", event_count, ec + 1);
      chk("bp_valid_drop", m_valid, 0);
      wait_valid(50);
      @(negedge clk); m_ready = 1'b1;
      wait_drain(200, 1'b0);

      // randomized rounds with random mask, ready and enable
      for (int r = 0; r < 6; r++) begin
         @(negedge clk);
         src_mask = NUM_SRC'($urandom_range(1, 15));
         for (int s = 0; s < NUM_SRC; s++) begin
            n = $urandom_range(0, 7);
            for (int k = 0; k < n; k++) push(s, DW'($urandom));
         end
         wait_drain(3000, 1'b1);
      end
      @(negedge clk);
      src_mask = '1; enable = 1'b1; m_ready = 1'b1;
      wait_drain(3000, 1'b0);

      // 6: reset mid-OUT, fresh round-robin start, clear versus handshake
      @(negedge clk);
      m_ready = 1'b0; enable = 1'b1;
      push(1, 16'h1111);
      push(1, 16'h2222);
      wait_valid(50);
      chk("pre_rst_valid", m_valid, 1);
      chk("pre_rst_busy", busy, 1);
      do_reset();
      @(negedge clk);
      base = hs_id.size();
      push(3, 16'h3333);
      push(0, 16'h0A0A);
      push(0, 16'h0B0B);
      m_ready = 1'b1;
      n = 0;
      while (hs_id.size() <= base && n < 50) begin
         @(negedge clk); #3;
         n++;
      end
      chk("post_rst_first_words", hs_id.size() > base, 1);
      if (hs_id.size() > base) chk("post_rst_first_grant", hs_id[base], 0);
      @(negedge clk); m_ready = 1'b0;
      wait_valid(50);
      @(negedge clk); m_ready = 1'b1; cnt_clr = 1'b1;
      @(negedge clk); cnt_clr = 1'b0;
      #3;
      chk("clr_beats_increment", event_count, 0);
      wait_drain(200, 1'b0);
      chk("count_after_clr", event_count, 1);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
